// File: rtl/led_frame_tx.sv
// WS2812-style strip transmitter: double-buffered colour RAM, frame serialiser (GRB, MSB first) and latch gap.
// Optional global dimming of every channel when LEDTX_DIM_EN is defined.
module led_frame_tx #(
   parameter int unsigned NUM_LEDS  = 30,
   parameter int unsigned T_BIT     = 186,
   parameter int unsigned T0H       = 59,
   parameter int unsigned T1H       = 119,
   parameter int unsigned RESET_CYC = 8000,
   parameter int unsigned DIM_SHIFT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [7:0]  wr_id,
   input  logic [23:0] wr_rgb,
   input  logic        frame_start,
   output logic        busy,
   output logic        frame_done,
   output logic        led_dout
);

   localparam int unsigned MAX_CYC = (T_BIT > RESET_CYC) ? T_BIT : RESET_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

`ifdef LEDTX_DIM_EN
   localparam bit DIM_EN = 1'b1;
`else
   localparam bit DIM_EN = 1'b0;
`endif
   localparam int unsigned DIM_AMT = DIM_EN ? DIM_SHIFT : 0;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_LATCH} state_e;

   state_e             state_q, state_d;
   logic               wr_bank_q, wr_bank_d;
   logic [7:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   cyc_q, cyc_d;
   logic [4:0]         bit_cnt_q, bit_cnt_d;
   logic [23:0]        shift_q, shift_d;
   logic               led_q, led_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [23:0]        mem_q [2][NUM_LEDS];
   logic [23:0]        rd_q;
   logic [23:0]        load_word;
   logic [CNT_W-1:0]   high_cyc;

   // Colour RAM: writes always target the write bank, reads always the frozen tx bank.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_id < 8'(NUM_LEDS))) begin
         mem_q[wr_bank_q][AW'(wr_id)] <= wr_rgb;
      end
      rd_q <= mem_q[~wr_bank_q][AW'(idx_q)];
   end

   // Reorder RGB to wire order GRB, optionally dimmed.
   assign load_word = {rd_q[15:8] >> DIM_AMT, rd_q[23:16] >> DIM_AMT, rd_q[7:0] >> DIM_AMT};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         wr_bank_q <= 1'b0;
         idx_q     <= '0;
         cyc_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next state; outputs are derived from the next state so the registered pins line up with state_q.
   always_comb begin
      state_d   = state_q;
      wr_bank_d = wr_bank_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               wr_bank_d = ~wr_bank_q;
               idx_d     = '0;
               cyc_d     = '0;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (cyc_q == '0) begin
               cyc_d = CNT_W'(1);
            end else begin
               shift_d   = load_word;
               bit_cnt_d = 5'd23;
               cyc_d     = '0;
               state_d   = S_BIT;
            end
         end
         S_BIT: begin
            if (cyc_q == CNT_W'(T_BIT - 1)) begin
               cyc_d = '0;
               if (bit_cnt_q != 5'd0) begin
                  shift_d   = {shift_q[22:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 5'd1;
               end else if (idx_q < 8'(NUM_LEDS - 1)) begin
                  idx_d   = idx_q + 8'd1;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_LATCH;
               end
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         S_LATCH: begin
            if (cyc_q == CNT_W'(RESET_CYC - 1)) begin
               cyc_d   = '0;
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      high_cyc = shift_d[23] ? CNT_W'(T1H) : CNT_W'(T0H);
      led_d    = (state_d == S_BIT) && (cyc_d < high_cyc);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_LATCH) && (cyc_d == CNT_W'(RESET_CYC - 1));
   end

   assign led_dout   = led_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
